// File: rtl/vpe_accum_if.sv
// Beat/result handshake bundle for vpe_accum.
// The master drives input beats and consumes results; the slave is the accumulator.
interface vpe_accum_if #(
  parameter int LANES      = 4,
  parameter int I_WIDTH    = 32,
  parameter int PSUM_WIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*I_WIDTH-1:0]    in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*PSUM_WIDTH-1:0] out_data;
  logic [LANES-1:0]            out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/vpe_accum.sv
// Multi-lane grouped accumulator: base + sum of len beats per lane, result held until taken.
// Define VPE_ACCUM_SAT_EN for saturating adds with a sticky per-lane out_sat; default wraps.
module vpe_accum_lane #(
  parameter int I_WIDTH    = 32,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  first,
  input  logic                  step,
  input  logic [PSUM_WIDTH-1:0] base,
  input  logic [I_WIDTH-1:0]    din,
  output logic [PSUM_WIDTH-1:0] acc,
  output logic                  sat
);
  logic signed [PSUM_WIDTH-1:0] a_op, d_x, res;

  assign d_x  = PSUM_WIDTH'($signed(din));
  assign a_op = first ? base : acc;

`ifdef VPE_ACCUM_SAT_EN
  localparam int SW = PSUM_WIDTH + 1;
  logic signed [PSUM_WIDTH:0] sum;
  logic                       ovf;

  assign sum = SW'(a_op) + SW'(d_x);
  // Top two bits disagree only when the add left the PSUM_WIDTH range.
  assign ovf = sum[PSUM_WIDTH] ^ sum[PSUM_WIDTH-1];
  assign res = !ovf ? sum[PSUM_WIDTH-1:0] :
               sum[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                               : {1'b0, {(PSUM_WIDTH-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (rst)        sat <= 1'b0;
    else if (first) sat <= ovf;
    else if (step)  sat <= sat | ovf;
  end
`else
  assign res = a_op + d_x;
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)                acc <= '0;
    else if (first || step) acc <= res;
  end
endmodule

module vpe_accum #(
  parameter int LANES      = 4,
  parameter int I_WIDTH    = 32,
  parameter int PSUM_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_enable,
  input  logic                        cfg_sel_psum_bias,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  input  logic [LANES*PSUM_WIDTH-1:0] bias_in,
  input  logic [LANES*PSUM_WIDTH-1:0] psum_in,
  vpe_accum_if.slave                  bus,
  output logic                        busy
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, count, count_inc, eff_len;
  logic                 accept, first_beat, step_beat;

  logic [LANES-1:0][PSUM_WIDTH-1:0] base_v, acc_v;
  logic [LANES-1:0][I_WIDTH-1:0]    din_v;
  logic [LANES-1:0]                 sat_v;

  assign accept     = bus.in_valid && bus.in_ready;
  assign first_beat = accept && (state == IDLE);
  assign step_beat  = accept && (state == ACC);
  assign count_inc  = count + LEN_WIDTH'(1);

  // Passthrough collapses the group to a single beat; zero length means one.
  always_comb begin
    eff_len = cfg_len;
    if (!cfg_enable || cfg_len == '0) eff_len = LEN_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (first_beat) begin
        count <= LEN_WIDTH'(1);
        len_q <= eff_len;
      end else if (step_beat) begin
        count <= count_inc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (first_beat) state_nxt = (eff_len == LEN_WIDTH'(1)) ? HOLD : ACC;
      ACC:  if (step_beat && count_inc == len_q) state_nxt = HOLD;
      HOLD: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state != HOLD);
    bus.out_valid = (state == HOLD);
    busy          = (state != IDLE);
  end

  // Base is only consumed on the first beat, so the live config selects it.
  assign base_v = cfg_enable ? (cfg_sel_psum_bias ? bias_in : psum_in) : '0;
  assign din_v  = bus.in_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vpe_accum_lane #(.I_WIDTH(I_WIDTH), .PSUM_WIDTH(PSUM_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .first (first_beat),
      .step  (step_beat),
      .base  (base_v[i]),
      .din   (din_v[i]),
      .acc   (acc_v[i]),
      .sat   (sat_v[i])
    );
  end

  assign bus.out_data = acc_v;
  assign bus.out_sat  = sat_v;
endmodule

// File: tb/tb_vpe_accum.sv
// Directed table-driven bench for vpe_accum (4 lanes, 16-bit in, 32-bit psum).
module tb_vpe_accum;
  localparam int LANES = 4, IW = 16, PW = 32, LW = 8;
`ifdef VPE_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_enable = 1'b0, cfg_sel_psum_bias = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [LANES*PW-1:0] bias_in = '0, psum_in = '0;
  logic busy;

  vpe_accum_if #(.LANES(LANES), .I_WIDTH(IW), .PSUM_WIDTH(PW)) bus ();

  vpe_accum #(.LANES(LANES), .I_WIDTH(IW), .PSUM_WIDTH(PW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_sel_psum_bias(cfg_sel_psum_bias),
    .cfg_len(cfg_len), .bias_in(bias_in), .psum_in(psum_in), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            en, sel;
    logic [LW-1:0]   len;
    int              nb, gap;
    logic [PW-1:0]   bias, psum;
    logic [3:0][IW-1:0] d;
    logic [PW-1:0]   exp;
    logic            exp_sat;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic en, logic sel, logic [LW-1:0] len, int nb, int gap,
                              logic [PW-1:0] bias, logic [PW-1:0] psum,
                              logic [IW-1:0] d0, logic [IW-1:0] d1, logic [IW-1:0] d2,
                              logic [IW-1:0] d3, logic [PW-1:0] exp, logic exp_sat);
    vec_t v;
    v.en = en; v.sel = sel; v.len = len; v.nb = nb; v.gap = gap;
    v.bias = bias; v.psum = psum; v.d = {d3, d2, d1, d0};
    v.exp = exp; v.exp_sat = exp_sat;
    return v;
  endfunction

  task automatic take_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ovalid_after_take"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_busy_after_take"}, 32'(busy), 32'd0);
  endtask

  task automatic run_group(input string tag, input vec_t v);
    cfg_enable = v.en; cfg_sel_psum_bias = v.sel; cfg_len = v.len;
    bias_in = {LANES{v.bias}}; psum_in = {LANES{v.psum}};
    for (int b = 0; b < v.nb; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {LANES{v.d[b]}};
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (b == 0) begin
        // Config churn after the first beat must not affect the group.
        cfg_enable = ~v.en; cfg_sel_psum_bias = ~v.sel; cfg_len = 8'd1;
        bias_in = {LANES{32'h5555_5555}}; psum_in = {LANES{32'h2222_2222}};
      end
      if (b < v.nb - 1) begin
        chk({tag, "_ovalid_mid"}, 32'(bus.out_valid), 32'd0);
        for (int g = 0; g < v.gap; g++) begin
          @(posedge clk); #1;
          chk({tag, "_busy_bubble"}, 32'(busy & ~bus.out_valid), 32'd1);
        end
      end
    end
    chk({tag, "_ovalid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_iready_hold"}, 32'(bus.in_ready), 32'd0);
    for (int l = 0; l < LANES; l++)
      chk($sformatf("%s_data_l%0d", tag, l), bus.out_data[l*PW +: PW], v.exp);
    chk({tag, "_sat"}, 32'(bus.out_sat), 32'({LANES{v.exp_sat}}));
    take_result(tag);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = mk(1, 1, 3, 3, 0, 32'd10, 32'd99, 16'd1, 16'd2, 16'd3, 16'd0, 32'd16, 1'b0);
    tbl[1] = mk(1, 0, 2, 2, 3, 32'd5, 32'd100, 16'hFFF9, 16'd20, 16'd0, 16'd0, 32'd113, 1'b0);
    tbl[2] = mk(1, 0, 0, 1, 0, 32'd0, 32'd0, 16'd9, 16'd0, 16'd0, 16'd0, 32'd9, 1'b0);
    tbl[3] = mk(0, 1, 5, 1, 0, 32'd77, 32'd1000, 16'hFFFB, 16'd0, 16'd0, 16'd0, 32'hFFFF_FFFB, 1'b0);
    tbl[4] = mk(1, 0, 1, 1, 0, 32'd0, 32'h7FFF_FFFF, 16'd1, 16'd0, 16'd0, 16'd0,
                SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
    tbl[5] = mk(1, 0, 1, 1, 0, 32'd0, 32'h8000_0000, 16'hFFFF, 16'd0, 16'd0, 16'd0,
                SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, SAT);
    tbl[6] = mk(1, 0, 2, 2, 0, 32'd0, 32'h7FFF_FFFE, 16'd5, 16'hFFF6, 16'd0, 16'd0,
                SAT ? 32'h7FFF_FFF5 : 32'h7FFF_FFF9, SAT);
    tbl[7] = mk(1, 1, 1, 1, 0, 32'hFFFF_FFFD, 32'd0, 16'd2, 16'd0, 16'd0, 16'd0, 32'hFFFF_FFFF, 1'b0);
    tbl[8] = mk(1, 0, 4, 4, 1, 32'd0, 32'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                32'hFFFE_0000, 1'b0);

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_iready", 32'(bus.in_ready), 32'd1);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_l0", bus.out_data[31:0], 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);

    for (int i = 0; i < 9; i++) run_group($sformatf("v%0d", i), tbl[i]);

    // Distinct per-lane bias and data check lane ordering.
    cfg_enable = 1'b1; cfg_sel_psum_bias = 1'b1; cfg_len = 8'd2;
    bias_in = {32'd400, 32'd300, 32'd200, 32'd100};
    bus.in_valid = 1'b1; bus.in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    @(posedge clk); #1;
    bus.in_data = {16'd40, 16'd30, 16'd20, 16'd10};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int l = 0; l < LANES; l++)
      chk($sformatf("lanes_l%0d", l), bus.out_data[l*PW +: PW], 32'(111 * (l + 1)));

    // Stall in HOLD with a beat pending: data stable, nothing accepted.
    bus.in_valid = 1'b1; bus.in_data = {LANES{16'h0123}};
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("stall_ovalid", 32'(bus.out_valid), 32'd1);
      chk("stall_iready", 32'(bus.in_ready), 32'd0);
      chk("stall_data_l3", bus.out_data[3*PW +: PW], 32'd444);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("stall_idle_busy", 32'(busy), 32'd0);
    chk("stall_idle_ovalid", 32'(bus.out_valid), 32'd0);
    chk("stall_no_accept", bus.out_data[0 +: PW], 32'd111);

    // Reset mid-group discards the partial sum.
    cfg_enable = 1'b1; cfg_sel_psum_bias = 1'b0; cfg_len = 8'd4; psum_in = {LANES{32'd50}};
    bus.in_valid = 1'b1; bus.in_data = {LANES{16'd3}};
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_iready", 32'(bus.in_ready), 32'd1);
    chk("mrst_data", bus.out_data[0 +: PW], 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mrst_ovalid", 32'(bus.out_valid), 32'd0);
    end
    run_group("post_rst", mk(1, 0, 1, 1, 0, 32'd0, 32'd7, 16'd0, 16'd0, 16'd0, 16'd0, 32'd7, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vpe_accum.md
VPE_ACCUM -- requirements
Module: vpe_accum

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent accumulation lanes.
REQ-002 SHALL have parameter I_WIDTH, default 32: signed input element width.
REQ-003 SHALL have parameter PSUM_WIDTH, default 32, >= I_WIDTH: signed accumulator and output element width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8: width of the group-length field.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port cfg_enable, input, 1: 1 = accumulate; 0 = passthrough (sign-extend only).
REQ-008 SHALL have port cfg_sel_psum_bias, input, 1: base select; 0 = psum_in, 1 = bias_in.
REQ-009 SHALL have port cfg_len, input, LEN_WIDTH: beats per group; 0 is treated as 1.
REQ-010 SHALL have port bias_in, input, LANES*PSUM_WIDTH: per-lane bias, lane 0 in the LSBs.
REQ-011 SHALL have port psum_in, input, LANES*PSUM_WIDTH: per-lane partial sum.
REQ-012 SHALL have port in_valid, input, 1: input beat valid.
REQ-013 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-014 SHALL have port in_data, input, LANES*I_WIDTH: per-lane signed input.
REQ-015 SHALL have port out_valid, output, 1: result valid.
REQ-016 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-017 SHALL have port out_data, output, LANES*PSUM_WIDTH: per-lane result, registered.
REQ-018 SHALL have port out_sat, output, LANES: per-lane sticky saturation flag for the group.
REQ-019 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACC and HOLD; in_ready = 1 in IDLE and ACC, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-021 SHALL treat a beat as accepted when in_valid && in_ready, and a result as taken when out_valid && out_ready.
REQ-022 SHALL, on the first accepted beat in IDLE, latch cfg_enable, cfg_sel_psum_bias and effective length; config changes later in the group SHALL be ignored.
REQ-023 SHALL, on the first beat, load acc[i] = base[i] + sext(in_data[i]), sampling base from bias_in or psum_in in that cycle only, and set count = 1.
REQ-024 SHALL, on each subsequent accepted beat in ACC, set acc[i] = acc[i] + sext(in_data[i]) and increment count.
REQ-025 SHALL transition to HOLD on the clock edge that accepts beat number len; a len=1 group goes IDLE -> HOLD directly.
REQ-026 SHALL make out_data valid one cycle after the last beat is accepted and hold it stable until taken.
REQ-027 SHALL return from HOLD to IDLE on the edge where the result is taken; no beat is accepted in that cycle.
REQ-028 SHALL, with latched cfg_enable = 0, force len = 1 and load acc[i] = sext(in_data[i]) with no base added.
REQ-029 SHALL stay in ACC with count unchanged when in_valid is low (bubbles allowed mid-group).
REQ-030 SHALL sign-extend all inputs from I_WIDTH to PSUM_WIDTH before any add.

Reset
REQ-031 SHALL, while rst is high at a clock edge, set state = IDLE, acc = 0, count = 0, out_sat = 0, out_valid = 0 and in_ready = 1 in the following cycle.
REQ-032 SHALL discard any partial group or unconsumed result when rst asserts mid-operation.

Configuration
REQ-033 SHALL, with macro VPE_ACCUM_SAT_EN defined, clamp each add to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1] and set out_sat[i] sticky for the group when lane i clamps; out_sat clears on the first beat of the next group.
REQ-034 SHALL, without VPE_ACCUM_SAT_EN, use two's-complement wrap-around and tie out_sat to 0; port list SHALL be identical in both builds.

Verification
REQ-035 SHALL cover: cfg_enable=1, sel=1, bias=10 on all lanes, len=3, in_data 1,2,3 -> one out_valid, out_data=16 on every lane, 1 cycle after beat 3.
REQ-036 SHALL cover: cfg_enable=0, in_data=-5 (I_WIDTH=16, PSUM_WIDTH=32) -> out_data=0xFFFFFFFB, len ignored, one result per beat.
REQ-037 SHALL cover: result in HOLD with out_ready=0 for 4 cycles -> out_data stable, in_ready=0, then out_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: psum=0x7FFFFFFF, in_data=1, len=1 -> with VPE_ACCUM_SAT_EN out_data=0x7FFFFFFF and out_sat=1; without it out_data=0x80000000 and out_sat=0.
REQ-039 SHALL cover: len=4, rst after beat 2 -> IDLE, out_valid never asserts; next group len=1, psum=7, in_data=0 -> out_data=7.
REQ-040 SHALL cover: len=0, in_data=9, psum=0 -> treated as len=1, out_data=9.
